// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan driver.
// Segment codes are common-anode, active-low, bit0 = segment a.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;

  // Entry n is the pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [23:0] value;
    logic [5:0]  dp;
    logic        lz_en;
    logic        valid;
  } disp_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bundle of the display-update request and the scanned display outputs.
interface seg_scan_driver_if;
  logic        load;
  logic [23:0] value;
  logic [5:0]  dp_in;
  logic        lz_en;
  logic [6:0]  seg;
  logic        dp_n;
  logic [5:0]  cs;
  logic        frame_tick;

  modport master (output load, value, dp_in, lz_en,
                  input  seg, dp_n, cs, frame_tick);
  modport slave  (input  load, value, dp_in, lz_en,
                  output seg, dp_n, cs, frame_tick);
endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to common-anode segment decode with blank override.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : hex_to_seg(nibble);
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed seven-segment driver with dead time between digits
// and frame-synchronous (tear-free) display updates.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEAD     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [23:0] value,
  input  logic [5:0]  dp_in,
  input  logic        lz_en,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [5:0]  cs,
  output logic        frame_tick
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  disp_t            pend_q, pend_d;
  disp_t            act_q, act_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_n_q, dp_n_d;
  logic [5:0]       cs_q, cs_d;
  logic             tick_q, tick_d;

  logic             cnt_wrap, last_digit, boundary, blank;
  logic [3:0]       cur_nib;
  logic [23:0]      upper;
  disp_t            load_word;

  seg_hex_decode u_dec (
    .nibble (cur_nib),
    .blank  (blank),
    .seg    (seg_d)
  );

  always_comb begin
    cnt_wrap   = (cnt_q == CNT_W'(SCAN_DIV - 1));
    last_digit = (idx_q == 3'(NUM_DIGITS - 1));
    boundary   = cnt_wrap && last_digit;

    cnt_d = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_wrap) idx_d = last_digit ? '0 : idx_q + 3'd1;

    load_word = '{value: value, dp: dp_in, lz_en: lz_en, valid: 1'b1};
    pend_d    = pend_q;
    act_d     = act_q;
    // A boundary-cycle load bypasses pending so it is shown from the very next frame.
    if (boundary) begin
      if (load)              act_d = load_word;
      else if (pend_q.valid) act_d = pend_q;
      pend_d.valid = 1'b0;
    end else if (load) begin
      pend_d = load_word;
    end

    upper   = act_q.value >> {idx_q, 2'b00};
    cur_nib = upper[3:0];
    // Active starts invalid after reset, keeping the display dark until a load lands.
    blank   = !act_q.valid || (act_q.lz_en && (idx_q != 3'd0) && (upper == '0));

    dp_n_d = ~act_q.dp[idx_q];
    cs_d   = '1;
    if (cnt_q >= CNT_W'(DEAD)) cs_d[idx_q] = 1'b0;
    tick_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      pend_q <= '0;
      act_q  <= '0;
      seg_q  <= SEG_BLANK;
      dp_n_q <= 1'b1;
      cs_q   <= '1;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      act_q  <= act_d;
      seg_q  <= seg_d;
      dp_n_q <= dp_n_d;
      cs_q   <= cs_d;
      tick_q <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign cs         = cs_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: cycle-level reference model plus directed checks.
module tb_seg_scan_driver;

  localparam int unsigned SD = 8;
  localparam int unsigned DT = 2;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   nsince = 0;

  seg_scan_driver_if bus ();

  seg_scan_driver #(.SCAN_DIV(SD), .DEAD(DT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (bus.load),
    .value      (bus.value),
    .dp_in      (bus.dp_in),
    .lz_en      (bus.lz_en),
    .seg        (bus.seg),
    .dp_n       (bus.dp_n),
    .cs         (bus.cs),
    .frame_tick (bus.frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_seg(input logic [23:0] v, input logic lz,
                                           input logic ok, input int d);
    logic [23:0] up;
    up = v >> (4 * d);
    if (!ok) return 7'h7F;
    if (lz && d > 0 && up == 24'h0) return 7'h7F;
    return tbl[up[3:0]];
  endfunction

  // Reference model: position derived from elapsed cycles since reset release.
  int          t;
  logic [23:0] p_val, a_val;
  logic [5:0]  p_dp, a_dp;
  logic        p_lz, a_lz, p_ok, a_ok;
  logic [6:0]  exp_seg  = 7'h7F;
  logic        exp_dp_n = 1'b1;
  logic [5:0]  exp_cs   = 6'h3F;
  logic        exp_tick = 1'b0;

  always @(posedge clk) begin
    int slot, dig;
    logic bnd;
    if (!rst_n) begin
      t = 0;
      p_val = '0; p_dp = '0; p_lz = 1'b0; p_ok = 1'b0;
      a_val = '0; a_dp = '0; a_lz = 1'b0; a_ok = 1'b0;
      exp_seg = 7'h7F; exp_dp_n = 1'b1; exp_cs = 6'h3F; exp_tick = 1'b0;
    end else begin
      slot = t % SD;
      dig  = (t / SD) % 6;
      bnd  = (slot == SD - 1) && (dig == 5);
      exp_seg  = model_seg(a_val, a_lz, a_ok, dig);
      exp_dp_n = ~a_dp[dig];
      exp_cs   = (slot < DT) ? 6'h3F : (6'h3F & ~(6'b1 << dig));
      exp_tick = bnd;
      if (bnd) begin
        if (bus.load) begin
          a_val = bus.value; a_dp = bus.dp_in; a_lz = bus.lz_en; a_ok = 1'b1;
        end else if (p_ok) begin
          a_val = p_val; a_dp = p_dp; a_lz = p_lz; a_ok = 1'b1;
        end
        p_ok = 1'b0;
      end else if (bus.load) begin
        p_val = bus.value; p_dp = bus.dp_in; p_lz = bus.lz_en; p_ok = 1'b1;
      end
      t++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_seg", 24'(bus.seg), 24'h7F);
      chk("rst_dp_n", 24'(bus.dp_n), 24'h1);
      chk("rst_cs", 24'(bus.cs), 24'h3F);
      chk("rst_tick", 24'(bus.frame_tick), 24'h0);
    end else begin
      chk("m_seg", 24'(bus.seg), 24'(exp_seg));
      chk("m_dp_n", 24'(bus.dp_n), 24'(exp_dp_n));
      chk("m_cs", 24'(bus.cs), 24'(exp_cs));
      chk("m_tick", 24'(bus.frame_tick), 24'(exp_tick));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
    nsince++;
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 200; i++) begin
      step();
      if (bus.frame_tick) begin
        nsince = 0;
        return;
      end
    end
    chk("tick_timeout", 24'h0, 24'h1);
  endtask

  task automatic go_slot(input int d, input int k);
    int target;
    target = 1 + d * SD + k;
    while (nsince < target) step();
  endtask

  task automatic do_load(input logic [23:0] v, input logic [5:0] dp, input logic lz);
    bus.load = 1'b1; bus.value = v; bus.dp_in = dp; bus.lz_en = lz;
    step();
    bus.load = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.lz_en = 1'b0;
    repeat (5) step();
    chk("reset_seg", 24'(bus.seg), 24'h7F);
    chk("reset_cs", 24'(bus.cs), 24'h3F);
    rst_n = 1'b1;

    do_load(24'h123456, 6'b000001, 1'b0);
    wait_tick();
    go_slot(0, 4);
    chk("dec_d0_seg", 24'(bus.seg), 24'h02);
    chk("dec_d0_dp", 24'(bus.dp_n), 24'h0);
    chk("dec_d0_cs", 24'(bus.cs), 24'h3E);
    go_slot(5, 4);
    chk("dec_d5_seg", 24'(bus.seg), 24'h79);
    chk("dec_d5_cs", 24'(bus.cs), 24'h1F);

    do_load(24'h000042, 6'b000000, 1'b1);
    wait_tick();
    go_slot(0, 4); chk("lz_d0", 24'(bus.seg), 24'h24);
    go_slot(1, 4); chk("lz_d1", 24'(bus.seg), 24'h19);
    go_slot(2, 4); chk("lz_d2", 24'(bus.seg), 24'h7F);
    go_slot(5, 4); chk("lz_d5", 24'(bus.seg), 24'h7F);

    do_load(24'h000000, 6'b000000, 1'b1);
    wait_tick();
    go_slot(0, 4); chk("lz0_d0", 24'(bus.seg), 24'h40);
    go_slot(3, 4); chk("lz0_d3", 24'(bus.seg), 24'h7F);

    wait_tick();
    do_load(24'h111111, 6'b000000, 1'b0);
    go_slot(1, 3);
    do_load(24'h222222, 6'b000000, 1'b0);
    go_slot(3, 4); chk("tear_hold", 24'(bus.seg), 24'h7F);
    wait_tick();
    go_slot(3, 4); chk("tear_b", 24'(bus.seg), 24'h24);
    go_slot(5, 6);
    do_load(24'h333333, 6'b000000, 1'b0);
    chk("bnd_tick", 24'(bus.frame_tick), 24'h1);
    nsince = 0;
    go_slot(0, 4); chk("bnd_show", 24'(bus.seg), 24'h30);

    wait_tick();
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      n++;
      if (bus.frame_tick) break;
    end
    chk("tick_period", 24'(n), 24'd48);
    nsince = 0;

    go_slot(3, 2);
    do_load(24'h000000, 6'b000000, 1'b0);
    go_slot(3, 4);
    rst_n = 1'b0;
    step();
    step();
    chk("midrst_seg", 24'(bus.seg), 24'h7F);
    rst_n = 1'b1;
    wait_tick();
    go_slot(0, 4); chk("midrst_blank0", 24'(bus.seg), 24'h7F);
    go_slot(3, 4); chk("midrst_blank3", 24'(bus.seg), 24'h7F);
    do_load(24'h000000, 6'b000000, 1'b0);
    wait_tick();
    go_slot(0, 4); chk("midrst_reload", 24'(bus.seg), 24'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles per digit slot (1 ms at 50 MHz); legal range 4..2^20.
REQ-002 SHALL have parameter DEAD, default 16, cycles per slot with all digit selects off; legal range 1..SCAN_DIV-1.
REQ-003 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port load  input  1  single-cycle request to capture value, dp_in and lz_en.
REQ-006 SHALL have port value  input  24  six hex nibbles; nibble k = value[4k+3:4k] drives digit k; digit 5 is most significant.
REQ-007 SHALL have port dp_in  input  6  decimal-point enable per digit, active-high.
REQ-008 SHALL have port lz_en  input  1  leading-zero suppression enable.
REQ-009 SHALL have port seg  output  7  segments g..a (bit0 = a), active-low, common-anode.
REQ-010 SHALL have port dp_n  output  1  decimal point, active-low.
REQ-011 SHALL have port cs  output  6  digit selects, active-low, at most one bit low.
REQ-012 SHALL have port frame_tick  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 SHALL hold a slot counter 0..SCAN_DIV-1 and a digit index 0..5, both incrementing and wrapping; the index advances when the counter wraps.
REQ-014 SHALL declare a frame boundary on the cycle where the counter is SCAN_DIV-1 and the index is 5.
REQ-015 SHALL keep a pending register (value, dp_in, lz_en, valid flag) and an active register; load writes pending and sets valid; a later load in the same frame overwrites it (last wins).
REQ-016 SHALL copy pending to active and clear valid at a frame boundary when valid is set; a load coinciding with the boundary cycle SHALL go directly to active.
REQ-017 SHALL decode the active nibble of the current digit using the common-anode table 0..F = 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex); blank = 7F.
REQ-018 With lz_en active, digit k (k >= 1) SHALL show blank when nibbles k..5 are all zero; digit 0 is never suppressed; dp_n follows dp_in regardless of suppression.
REQ-019 SHALL drive cs all-high while slot counter < DEAD, else cs[index] low and the others high.
REQ-020 All outputs SHALL be registered, reflecting counter/index/active state with exactly 1 cycle of latency.
REQ-021 frame_tick SHALL be high for one cycle, the cycle after the frame boundary.

Reset
REQ-022 While rst_n is low: counter = 0, index = 0, active and pending cleared (value 0, dp 0, lz_en 0, valid 0), seg = 7F, dp_n = 1, cs = 3F, frame_tick = 0.
REQ-023 Reset assertion mid-frame SHALL discard any pending load; after release, scanning SHALL restart at digit 0 slot cycle 0.

Structure
REQ-024 The shared package seg_pkg SHALL hold the 16-entry decode constants, SEG_BLANK = 7F, and NUM_DIGITS = 6.
REQ-025 Hex-to-segment decode SHALL be a combinational sub-module seg_hex_decode (4-bit nibble plus blank input, 7-bit output).

Verification (SCAN_DIV = 8, DEAD = 2)
REQ-026 Reset scenario: hold rst_n low for 5 cycles -> seg = 7F, cs = 3F, dp_n = 1, frame_tick = 0 throughout.
REQ-027 Decode scenario: load value = 123456, dp_in = 000001b -> after next frame_tick, digit 0 slot shows seg = 02 and dp_n = 0; digit 5 slot shows seg = 79; cs pattern is 111110b for digit 0 and 011111b for digit 5.
REQ-028 Leading-zero scenario: value = 000042 with lz_en = 1 -> digits 5..2 show seg = 7F and digit 1 shows 19; value = 000000 -> digit 0 shows 40 and all other digits show 7F.
REQ-029 Tearing scenario: load A mid-frame, then load B in the same frame -> display is unchanged until frame_tick, then shows B; a load on the boundary cycle is displayed from the next frame.
REQ-030 Dead-time scenario: in every slot, cs = 3F for exactly 2 cycles, then has one low bit for 6 cycles; frame_tick recurs every 48 cycles.
REQ-031 Reset-mid-run scenario: assert rst_n during the digit 3 slot with a pending load -> after release, the display is blank and shows 40 only after a new load.
